// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment display driver: active-low glyphs,
// display mode encodings, control FSM states and small helper functions.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    MODE_UNS = 2'd0,
    MODE_NEG = 2'd1,
    MODE_ERR = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } ctrl_state_e;

  function automatic logic [7:0] digit_glyph(input logic [3:0] d);
    logic [7:0] g;
    case (d)
      4'd0:    g = SEG_0;
      4'd1:    g = SEG_1;
      4'd2:    g = SEG_2;
      4'd3:    g = SEG_3;
      4'd4:    g = SEG_4;
      4'd5:    g = SEG_5;
      4'd6:    g = SEG_6;
      4'd7:    g = SEG_7;
      4'd8:    g = SEG_8;
      4'd9:    g = SEG_9;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// done is high during the final iteration so the caller can commit on the next edge.
module bin2bcd_seq #(
  parameter int BIN_W  = 11,
  parameter int DIGITS = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  logic [BIN_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Every BCD nibble of 5 or more gets +3 so the following shift carries correctly.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  assign done = busy_q && (cnt_q == CNT_W'(BIN_W - 1));

  always_comb begin
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    if (start) begin
      shift_d = bin;
      bcd_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      bcd_d   = {adj[BCD_W-2:0], shift_q[BIN_W-1]};
      shift_d = shift_q << 1;
      cnt_d   = cnt_q + CNT_W'(1);
      if (done) busy_d = 1'b0;
    end
  end

  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode 7-segment driver: captures a value, converts it to BCD in the
// background, commits it atomically to shadow registers and scans the digits from there.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int DATA_W   = 11,
  parameter int PRESCALE = 4096,
  parameter int BLANK_LZ = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] value,
  input  logic [1:0]        mode,
  input  logic [DIGITS-1:0] dp,
  output logic              ready,
  output logic [DIGITS-1:0] anodes,
  output logic [7:0]        segments
);

  localparam int          BCD_W   = 4 * DIGITS;
  localparam int          IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int          PRESC_W = $clog2(PRESCALE);
  localparam logic [31:0] UNS_MAX = pow10(DIGITS) - 32'd1;
  localparam logic [31:0] NEG_MAX = pow10(DIGITS - 1) - 32'd1;

  ctrl_state_e       state_q, state_d;
  logic              accept, commit;
  logic              conv_busy, conv_done;
  logic [BCD_W-1:0]  conv_bcd;

  mode_e             cap_mode_q, cap_mode_d;
  logic [DIGITS-1:0] cap_dp_q, cap_dp_d;
  logic [BCD_W-1:0]  sh_bcd_q, sh_bcd_d;
  mode_e             sh_mode_q, sh_mode_d;
  logic [DIGITS-1:0] sh_dp_q, sh_dp_d;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               lit_q, lit_d;
  logic               wrap;
  logic [DIGITS-1:0]  anodes_q, anodes_d;
  logic [7:0]         seg_q, seg_d;

  logic               overflow;
  logic [IDX_W-1:0]   msd;
  logic [IDX_W-1:0]   minus_pos;
  logic [3:0]         cur_digit;
  logic [7:0]         glyph;

  bin2bcd_seq #(
    .BIN_W  (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .start (accept),
    .bin   (value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_CONV;
      ST_CONV:   if (conv_done) state_d = ST_COMMIT;
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ready  = (state_q == ST_IDLE) && !conv_busy;
    accept = load && ready;
    commit = (state_q == ST_COMMIT);
  end

  // Range check happens at capture time so only the resulting mode needs storing.
  always_comb begin
    overflow = 1'b0;
    if (mode_e'(mode) == MODE_UNS && 32'(value) > UNS_MAX) overflow = 1'b1;
    if (mode_e'(mode) == MODE_NEG && 32'(value) > NEG_MAX) overflow = 1'b1;
  end

  always_comb begin
    cap_mode_d = cap_mode_q;
    cap_dp_d   = cap_dp_q;
    sh_bcd_d   = sh_bcd_q;
    sh_mode_d  = sh_mode_q;
    sh_dp_d    = sh_dp_q;
    if (accept) begin
      cap_mode_d = overflow ? MODE_ERR : mode_e'(mode);
      cap_dp_d   = dp;
    end
    if (commit) begin
      sh_bcd_d  = conv_bcd;
      sh_mode_d = cap_mode_q;
      sh_dp_d   = cap_dp_q;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cap_mode_q <= MODE_UNS;
      cap_dp_q   <= '0;
      sh_bcd_q   <= '0;
      sh_mode_q  <= MODE_UNS;
      sh_dp_q    <= '0;
    end else begin
      cap_mode_q <= cap_mode_d;
      cap_dp_q   <= cap_dp_d;
      sh_bcd_q   <= sh_bcd_d;
      sh_mode_q  <= sh_mode_d;
      sh_dp_q    <= sh_dp_d;
    end
  end

  // The first prescaler wrap only switches the display on; later wraps step the index.
  always_comb begin
    wrap    = (presc_q == PRESC_W'(PRESCALE - 1));
    presc_d = wrap ? '0 : presc_q + PRESC_W'(1);
    idx_d   = idx_q;
    lit_d   = lit_q;
    if (wrap) begin
      if (!lit_q) lit_d = 1'b1;
      else        idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    msd = '0;
    for (int j = 0; j < DIGITS; j++) begin
      if (sh_bcd_q[4*j +: 4] != 4'd0) msd = IDX_W'(j);
    end
    if (BLANK_LZ == 0)                     minus_pos = IDX_W'(DIGITS - 1);
    else if (msd == IDX_W'(DIGITS - 1))    minus_pos = msd;
    else                                   minus_pos = msd + IDX_W'(1);
    cur_digit = sh_bcd_q[{idx_q, 2'b00} +: 4];
  end

  always_comb begin
    glyph = SEG_BLANK;
    case (sh_mode_q)
      MODE_UNS: begin
        if (BLANK_LZ != 0 && idx_q > msd) glyph = SEG_BLANK;
        else                              glyph = digit_glyph(cur_digit);
      end
      MODE_NEG: begin
        if (idx_q == minus_pos)     glyph = SEG_MINUS;
        else if (idx_q > minus_pos) glyph = SEG_BLANK;
        else                        glyph = digit_glyph(cur_digit);
      end
      MODE_ERR: glyph = (idx_q == '0) ? SEG_E : SEG_BLANK;
      default:  glyph = SEG_BLANK;
    endcase
    if (sh_mode_q != MODE_ERR && sh_dp_q[idx_q] && glyph != SEG_BLANK) glyph[7] = 1'b0;
    anodes_d = lit_q ? ~(DIGITS'(1) << idx_q) : '1;
    seg_d    = lit_q ? glyph : SEG_BLANK;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      presc_q  <= '0;
      idx_q    <= '0;
      lit_q    <= 1'b0;
      anodes_q <= '1;
      seg_q    <= SEG_BLANK;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      lit_q    <= lit_d;
      anodes_q <= anodes_d;
      seg_q    <= seg_d;
    end
  end

  assign anodes   = anodes_q;
  assign segments = seg_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Randomised bench for seg_scan_display: two instances (leading-zero blanking on/off)
// compared every cycle against an arithmetic model of the display contents and timing.
module tb_seg_scan_display;

  localparam int D = 4;
  localparam int W = 14;
  localparam int P = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          load = 1'b0;
  logic [W-1:0]  value = '0;
  logic [1:0]    mode = '0;
  logic [D-1:0]  dp = '0;
  logic          readyA, readyB;
  logic [D-1:0]  anodesA, anodesB;
  logic [7:0]    segA, segB;

  int totalChecks = 0;
  int badChecks = 0;

  int n;
  bit pending;
  bit mReady;
  int commitAt;
  int pVal, pMode, pDp;
  int sVal, sMode, sDp;

  always #5 clk = ~clk;

  seg_scan_display #(.DIGITS(D), .DATA_W(W), .PRESCALE(P), .BLANK_LZ(1)) dutA (
    .Clk(clk), .Rst_n(rst_n), .load(load), .value(value), .mode(mode), .dp(dp),
    .ready(readyA), .anodes(anodesA), .segments(segA)
  );

  seg_scan_display #(.DIGITS(D), .DATA_W(W), .PRESCALE(P), .BLANK_LZ(0)) dutB (
    .Clk(clk), .Rst_n(rst_n), .load(load), .value(value), .mode(mode), .dp(dp),
    .ready(readyB), .anodes(anodesB), .segments(segB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [7:0] glyphOf(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0; 4: return 8'h99;
      5: return 8'h92; 6: return 8'h82; 7: return 8'hF8; 8: return 8'h80; 9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int pow10i(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  // What digit k of a display holding (val, md, dpm) should show.
  function automatic logic [7:0] render(input int val, input int md, input int dpm,
                                        input int k, input bit blz);
    int effMode = md;
    int sig = 1;
    int mpos;
    int dig;
    logic [7:0] g;
    if (md == 0 && val > pow10i(D) - 1) effMode = 2;
    if (md == 1 && val > pow10i(D - 1) - 1) effMode = 2;
    for (int i = 1; i < D; i++) if (val >= pow10i(i)) sig = i + 1;
    dig = (val / pow10i(k)) % 10;
    case (effMode)
      0: g = (blz && k >= sig) ? 8'hFF : glyphOf(dig);
      1: begin
        mpos = blz ? sig : D - 1;
        if (k == mpos)     g = 8'hBF;
        else if (k > mpos) g = 8'hFF;
        else               g = glyphOf(dig);
      end
      2: return (k == 0) ? 8'h86 : 8'hFF;
      default: g = 8'hFF;
    endcase
    if (((dpm >> k) & 1) == 1 && g != 8'hFF) g[7] = 1'b0;
    return g;
  endfunction

  // One clock edge: predict outputs from the model, advance it, then compare.
  task automatic tick();
    bit accept;
    bit lit;
    int k;
    logic [7:0] eA, eB;
    logic [D-1:0] eAn;
    accept = load && mReady;
    @(posedge clk);
    n++;
    lit = (n >= P + 1);
    k = lit ? (((n - 1) / P - 1) % D) : 0;
    eA  = lit ? render(sVal, sMode, sDp, k, 1'b1) : 8'hFF;
    eB  = lit ? render(sVal, sMode, sDp, k, 1'b0) : 8'hFF;
    eAn = lit ? ~(D'(1) << k) : '1;
    if (pending && n == commitAt) begin
      sVal = pVal; sMode = pMode; sDp = pDp;
      pending = 1'b0;
    end
    if (accept) begin
      pending = 1'b1;
      pVal = int'(value); pMode = int'(mode); pDp = int'(dp);
      commitAt = n + W + 1;
    end
    mReady = !pending;
    #1;
    checkOutput("readyA", 32'(readyA), 32'(mReady));
    checkOutput("readyB", 32'(readyB), 32'(mReady));
    checkOutput("anodesA", 32'(anodesA), 32'(eAn));
    checkOutput("anodesB", 32'(anodesB), 32'(eAn));
    checkOutput("segA", 32'(segA), 32'(eA));
    checkOutput("segB", 32'(segB), 32'(eB));
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    load = 1'b0;
    #1;
    checkOutput("rstReady", 32'(readyA & readyB), 32'd1);
    checkOutput("rstSegA", 32'(segA), 32'hFF);
    checkOutput("rstSegB", 32'(segB), 32'hFF);
    checkOutput("rstAnodes", 32'({anodesA, anodesB}), 32'hFF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; pending = 1'b0; mReady = 1'b1; commitAt = 0;
    sVal = 0; sMode = 0; sDp = 0;
  endtask

  task automatic applyStimulus(input int v, input int m, input int d);
    value = W'(v);
    mode = 2'(m);
    dp = D'(d);
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    int cnt;
    int sel;
    #2;
    doReset();
    run(2 * P * D);

    applyStimulus(1234, 0, 0);
    cnt = 0;
    while (!readyA && cnt < 100) begin
      cnt++;
      tick();
    end
    checkOutput("loadLatency", 32'(cnt), 32'(W + 1));
    run(2 * P * D);

    applyStimulus(7, 1, 0);       run(W + 2 * P * D);
    applyStimulus(10000, 0, 0);   run(W + 2 * P * D);
    applyStimulus(1000, 1, 4'hF); run(W + 2 * P * D);
    applyStimulus(0, 1, 0);       run(W + 2 * P * D);
    applyStimulus(305, 3, 4'h5);  run(W + 2 * P * D);

    applyStimulus(42, 0, 4'b0010);
    run(5);
    applyStimulus(999, 0, 4'b1111);
    run(W + 2 * P * D);

    applyStimulus(8765, 0, 4'b1000);
    run(4);
    doReset();
    run(3 * P * D);

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 2);
      case (sel)
        0: value = W'($urandom_range(0, 999));
        1: value = W'($urandom_range(0, 9999));
        default: value = W'($urandom_range(0, (1 << W) - 1));
      endcase
      applyStimulus(int'(value), $urandom_range(0, 3), $urandom_range(0, 15));
      run($urandom_range(3, 45));
    end
    run(W + 2 * P * D);

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
